// File: rtl/id_decode_control_if.sv
// Fetch/decode bus: preload port, fetch address, IF/ID register and ID-stage controls.
// The optional illegal_instr output exists only with ILLEGAL_INSTR_DETECT_EN defined.
interface id_decode_control_if #(
    parameter int ADDR_W = 8
);
    logic              LE;
    logic              S;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              jmpl_instr;
    logic              Read_Write;
    logic              SE_dm;
    logic              load_instr;
    logic              RF_enable;
    logic              modifyCC;
    logic              Call_instr;
    logic              B_instr;
    logic              a_bit;
    logic [1:0]        size_dm;
    logic [5:0]        ALU_op3;
`ifdef ILLEGAL_INSTR_DETECT_EN
    logic              illegal_instr;
`endif

    modport master (
`ifdef ILLEGAL_INSTR_DETECT_EN
        input  illegal_instr,
`endif
        output LE, S, mem_we, mem_waddr, mem_wdata, pc,
        input  instr, jmpl_instr, Read_Write, SE_dm, load_instr, RF_enable,
        input  modifyCC, Call_instr, B_instr, a_bit, size_dm, ALU_op3
    );

    modport slave (
`ifdef ILLEGAL_INSTR_DETECT_EN
        output illegal_instr,
`endif
        input  LE, S, mem_we, mem_waddr, mem_wdata, pc,
        output instr, jmpl_instr, Read_Write, SE_dm, load_instr, RF_enable,
        output modifyCC, Call_instr, B_instr, a_bit, size_dm, ALU_op3
    );
endinterface

// File: rtl/id_decode_control.sv
// IF/ID stage: byte instruction memory, IF/ID register, decode and bubble mux.
// Optional illegal-instruction flag is enabled by defining ILLEGAL_INSTR_DETECT_EN.
module id_decode_control #(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 2 ** ADDR_W
) (
    input logic               Clk,
    input logic               R,
    id_decode_control_if.slave bus
);
    typedef struct packed {
        logic       jmpl_instr;
        logic       read_write;
        logic       se_dm;
        logic       load_instr;
        logic       rf_enable;
        logic       modify_cc;
        logic       call_instr;
        logic       b_instr;
        logic       a_bit;
        logic [1:0] size_dm;
        logic [5:0] alu_op3;
    } ctrl_t;

    logic [7:0]        mem [MEM_DEPTH];
    logic [ADDR_W-1:0] addr1, addr2, addr3;
    logic [31:0]       fetch;
    logic [31:0]       instr_q;
    logic [1:0]        op;
    logic [2:0]        op2;
    logic [5:0]        op3;
    ctrl_t             dec;
    ctrl_t             ctrl;
`ifdef ILLEGAL_INSTR_DETECT_EN
    logic              ill_d;
`endif

    always_ff @(posedge Clk) begin
        if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    end

    // Address width arithmetic gives the modulo-MEM_DEPTH wrap for free.
    assign addr1 = bus.pc + ADDR_W'(1);
    assign addr2 = bus.pc + ADDR_W'(2);
    assign addr3 = bus.pc + ADDR_W'(3);
    assign fetch = {mem[bus.pc], mem[addr1], mem[addr2], mem[addr3]};

    always_ff @(posedge Clk or negedge R) begin
        if (!R)          instr_q <= '0;
        else if (bus.LE) instr_q <= fetch;
    end

    assign op  = instr_q[31:30];
    assign op2 = instr_q[24:22];
    assign op3 = instr_q[24:19];

    always_comb begin
        dec = '0;
`ifdef ILLEGAL_INSTR_DETECT_EN
        ill_d = 1'b0;
`endif
        case (op)
            2'b01: begin
                dec.call_instr = 1'b1;
                dec.rf_enable  = 1'b1;
            end
            2'b00: begin
                case (op2)
                    3'b010: begin
                        dec.b_instr = 1'b1;
                        dec.a_bit   = instr_q[29];
                    end
                    3'b100: begin
                        dec.rf_enable = 1'b1;
                        dec.alu_op3   = 6'b001110;
                    end
                    default: begin
`ifdef ILLEGAL_INSTR_DETECT_EN
                        ill_d = (instr_q != '0);
`endif
                    end
                endcase
            end
            2'b10: begin
                if (!op3[5]) begin
                    dec.rf_enable = 1'b1;
                    dec.alu_op3   = op3;
                    dec.modify_cc = op3[4];
                end else if (op3 == 6'b100101 || op3 == 6'b100110 || op3 == 6'b100111) begin
                    dec.rf_enable = 1'b1;
                    dec.alu_op3   = op3;
                end else if (op3 == 6'b111000) begin
                    dec.jmpl_instr = 1'b1;
                    dec.rf_enable  = 1'b1;
                end else begin
`ifdef ILLEGAL_INSTR_DETECT_EN
                    ill_d = 1'b1;
`endif
                end
            end
            default: begin
                if (op3[2]) begin
                    dec.read_write = 1'b1;
                end else begin
                    dec.load_instr = 1'b1;
                    dec.rf_enable  = 1'b1;
                    dec.se_dm      = op3[3];
                end
                // Encoded size: byte, half, word, double.
                case (op3[1:0])
                    2'b01:   dec.size_dm = 2'b00;
                    2'b10:   dec.size_dm = 2'b01;
                    2'b00:   dec.size_dm = 2'b10;
                    default: dec.size_dm = 2'b11;
                endcase
            end
        endcase
    end

    assign ctrl = bus.S ? '0 : dec;

    assign bus.instr      = instr_q;
    assign bus.jmpl_instr = ctrl.jmpl_instr;
    assign bus.Read_Write = ctrl.read_write;
    assign bus.SE_dm      = ctrl.se_dm;
    assign bus.load_instr = ctrl.load_instr;
    assign bus.RF_enable  = ctrl.rf_enable;
    assign bus.modifyCC   = ctrl.modify_cc;
    assign bus.Call_instr = ctrl.call_instr;
    assign bus.B_instr    = ctrl.b_instr;
    assign bus.a_bit      = ctrl.a_bit;
    assign bus.size_dm    = ctrl.size_dm;
    assign bus.ALU_op3    = ctrl.alu_op3;
`ifdef ILLEGAL_INSTR_DETECT_EN
    assign bus.illegal_instr = ill_d & ~bus.S;
`endif
endmodule

// File: tb/tb_id_decode_control.sv
// Bench for id_decode_control: directed table, hand sequences, randomized run vs. a kind-based model.
// Works with and without ILLEGAL_INSTR_DETECT_EN.
module tb_id_decode_control;
    typedef struct packed {
        logic       ill;
        logic       call;
        logic       b;
        logic       a;
        logic       jmpl;
        logic       rf;
        logic       mcc;
        logic       ld;
        logic       rw;
        logic       se;
        logic [1:0] size;
        logic [5:0] alu;
    } ctrl_t;

    typedef struct {
        logic [31:0] word;
        logic        s;
        ctrl_t       exp;
    } vec_t;

    typedef enum {K_NONE, K_ILLEGAL, K_CALL, K_BRANCH, K_SETHI, K_ALU, K_SHIFT,
                  K_JMPL, K_LOAD, K_STORE} kind_t;

`ifdef ILLEGAL_INSTR_DETECT_EN
    localparam bit HAS_ILL = 1'b1;
`else
    localparam bit HAS_ILL = 1'b0;
`endif

    logic Clk = 1'b0;
    logic R   = 1'b0;
    always #5 Clk = ~Clk;

    id_decode_control_if #(.ADDR_W(8)) bus ();
    id_decode_control #(.ADDR_W(8), .MEM_DEPTH(256)) dut (.Clk(Clk), .R(R), .bus(bus));

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  m_mem [256];
    logic [31:0] m_instr = '0;
    vec_t        tbl [15];

    function automatic ctrl_t mkc(input logic call, b, a, jmpl, rf, mcc, ld, rw, se,
                                  input logic [1:0] size, input logic [5:0] alu, input logic ill);
        ctrl_t c;
        c = '{ill: ill & HAS_ILL, call: call, b: b, a: a, jmpl: jmpl, rf: rf, mcc: mcc,
              ld: ld, rw: rw, se: se, size: size, alu: alu};
        return c;
    endfunction

    function automatic kind_t classify(input logic [31:0] w);
        int op, f, op2;
        op  = int'(w[31:30]);
        f   = int'(w[24:19]);
        op2 = int'(w[24:22]);
        if (op == 1) return K_CALL;
        if (op == 0) begin
            if (op2 == 2) return K_BRANCH;
            if (op2 == 4) return K_SETHI;
            return (w == 0) ? K_NONE : K_ILLEGAL;
        end
        if (op == 2) begin
            if (f < 32) return K_ALU;
            if (f >= 37 && f <= 39) return K_SHIFT;
            if (f == 56) return K_JMPL;
            return K_ILLEGAL;
        end
        return ((f / 4) % 2 == 1) ? K_STORE : K_LOAD;
    endfunction

    function automatic ctrl_t model_ctrl(input logic [31:0] w, input logic s);
        ctrl_t      c;
        kind_t      k;
        int         f;
        logic [1:0] size_lut [4];
        size_lut = '{2'd2, 2'd0, 2'd1, 2'd3};
        c = '0;
        k = classify(w);
        f = int'(w[24:19]);
        case (k)
            K_CALL:    begin c.call = 1; c.rf = 1; end
            K_BRANCH:  begin c.b = 1; c.a = w[29]; end
            K_SETHI:   begin c.rf = 1; c.alu = 6'd14; end
            K_ALU:     begin c.rf = 1; c.alu = 6'(f); c.mcc = (f >= 16); end
            K_SHIFT:   begin c.rf = 1; c.alu = 6'(f); end
            K_JMPL:    begin c.jmpl = 1; c.rf = 1; end
            K_LOAD:    begin c.ld = 1; c.rf = 1; c.se = ((f / 8) % 2 == 1); c.size = size_lut[f % 4]; end
            K_STORE:   begin c.rw = 1; c.size = size_lut[f % 4]; end
            K_ILLEGAL: c.ill = HAS_ILL;
            default:   c = '0;
        endcase
        return s ? ctrl_t'(0) : c;
    endfunction

    function automatic ctrl_t actual();
        ctrl_t c;
        c.call = bus.Call_instr;  c.b  = bus.B_instr;   c.a  = bus.a_bit;
        c.jmpl = bus.jmpl_instr;  c.rf = bus.RF_enable; c.mcc = bus.modifyCC;
        c.ld   = bus.load_instr;  c.rw = bus.Read_Write; c.se = bus.SE_dm;
        c.size = bus.size_dm;     c.alu = bus.ALU_op3;
`ifdef ILLEGAL_INSTR_DETECT_EN
        c.ill = bus.illegal_instr;
`else
        c.ill = 1'b0;
`endif
        return c;
    endfunction

    function automatic logic [31:0] m_fetch(input logic [7:0] p);
        return {m_mem[p], m_mem[p + 8'd1], m_mem[p + 8'd2], m_mem[p + 8'd3]};
    endfunction

    task automatic check_exp(input string name, input logic [31:0] ei, input ctrl_t ec);
        ctrl_t got;
        got = actual();
        vectors++;
        if (bus.instr !== ei) begin
            miscompares++;
            $display("FAIL %s: instr got %h expected %h", name, bus.instr, ei);
        end
        vectors++;
        if (got !== ec) begin
            miscompares++;
            $display("FAIL %s: ctrl got %b expected %b", name, got, ec);
        end
    endtask

    task automatic check_model(input string name);
        check_exp(name, m_instr, model_ctrl(m_instr, bus.S));
    endtask

    // One clock edge with the model updated from the inputs seen at that edge.
    task automatic tick();
        @(posedge Clk);
        if (R && bus.LE) m_instr = m_fetch(bus.pc);
        if (bus.mem_we) m_mem[bus.mem_waddr] = bus.mem_wdata;
        #1;
    endtask

    task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
        bus.mem_we = 1'b1; bus.mem_waddr = a; bus.mem_wdata = d;
        tick();
        bus.mem_we = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [31:0] w);
        write_byte(a,        w[31:24]);
        write_byte(a + 8'd1, w[23:16]);
        write_byte(a + 8'd2, w[15:8]);
        write_byte(a + 8'd3, w[7:0]);
    endtask

    function automatic logic [31:0] crafted_word();
        logic [31:0] w;
        logic [5:0]  picks [8];
        picks = '{6'd56, 6'd37, 6'd38, 6'd39, 6'd16, 6'd0, 6'd4, 6'd10};
        w = $urandom;
        if ($urandom_range(0, 1) == 1) w[24:19] = picks[$urandom_range(0, 7)];
        return w;
    endfunction

    initial begin
        bus.LE = 0; bus.S = 0; bus.mem_we = 0; bus.mem_waddr = 0; bus.mem_wdata = 0; bus.pc = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

        #2;
        check_exp("reset_s0", 32'h0, '0);
        bus.S = 1; #1;
        check_exp("reset_s1", 32'h0, '0);
        bus.S = 0;
        #4 R = 1;

        for (int a = 0; a < 256; a += 4) write_word(8'(a), crafted_word());

        tbl[0]  = '{32'h40000010, 1'b0, mkc(1,0,0,0,1,0,0,0,0,2'b00,6'h00,0)};
        tbl[1]  = '{32'h30800004, 1'b0, mkc(0,1,1,0,0,0,0,0,0,2'b00,6'h00,0)};
        tbl[2]  = '{32'h86804002, 1'b0, mkc(0,0,0,0,1,1,0,0,0,2'b00,6'b010000,0)};
        tbl[3]  = '{32'h81C3E008, 1'b0, mkc(0,0,0,1,1,0,0,0,0,2'b00,6'h00,0)};
        tbl[4]  = '{32'hC6084002, 1'b0, mkc(0,0,0,0,1,0,1,0,0,2'b00,6'h00,0)};
        tbl[5]  = '{32'hC6284002, 1'b0, mkc(0,0,0,0,0,0,0,1,0,2'b00,6'h00,0)};
        tbl[6]  = '{32'h03000010, 1'b0, mkc(0,0,0,0,1,0,0,0,0,2'b00,6'b001110,0)};
        tbl[7]  = '{32'hC6504002, 1'b0, mkc(0,0,0,0,1,0,1,0,1,2'b01,6'h00,0)};
        tbl[8]  = '{32'h87284002, 1'b0, mkc(0,0,0,0,1,0,0,0,0,2'b00,6'b100101,0)};
        tbl[9]  = '{32'h87804002, 1'b0, mkc(0,0,0,0,0,0,0,0,0,2'b00,6'h00,1)};
        tbl[10] = '{32'hC6184002, 1'b0, mkc(0,0,0,0,1,0,1,0,0,2'b11,6'h00,0)};
        tbl[11] = '{32'hC6384002, 1'b0, mkc(0,0,0,0,0,0,0,1,0,2'b11,6'h00,0)};
        tbl[12] = '{32'h00000005, 1'b0, mkc(0,0,0,0,0,0,0,0,0,2'b00,6'h00,1)};
        tbl[13] = '{32'h86084002, 1'b0, mkc(0,0,0,0,1,0,0,0,0,2'b00,6'b000001,0)};
        tbl[14] = '{32'h86804002, 1'b1, mkc(0,0,0,0,0,0,0,0,0,2'b00,6'h00,0)};

        for (int i = 0; i < 15; i++) begin
            write_word(8'(4 * i), tbl[i].word);
            bus.pc = 8'(4 * i); bus.LE = 1; bus.S = tbl[i].s;
            tick();
            bus.LE = 0;
            check_exp($sformatf("table_%0d", i), tbl[i].word, tbl[i].exp);
            bus.S = 0;
        end

        // Bubble on addcc, then release.
        bus.pc = 8'd8; bus.LE = 1; tick(); bus.LE = 0;
        bus.S = 1; #1;
        check_exp("bubble_on", 32'h86804002, '0);
        bus.S = 0; #1;
        check_exp("bubble_off", 32'h86804002, mkc(0,0,0,0,1,1,0,0,0,2'b00,6'b010000,0));

        // Asynchronous reset mid-cycle, held across an LE edge, released mid-cycle.
        #1 R = 0; m_instr = '0; #1;
        check_exp("reset_async", 32'h0, '0);
        bus.LE = 1; tick();
        check_exp("reset_beats_le", 32'h0, '0);
        #2 R = 1; bus.pc = 8'd8; tick();
        check_exp("reset_release_reload", 32'h86804002, mkc(0,0,0,0,1,1,0,0,0,2'b00,6'b010000,0));

        // Write and fetch of the same byte on one edge: old value first, new value next.
        bus.pc = 8'd12; bus.LE = 1;
        bus.mem_we = 1; bus.mem_waddr = 8'd12; bus.mem_wdata = 8'h11;
        tick();
        bus.mem_we = 0;
        check_exp("same_byte_old", 32'h81C3E008, model_ctrl(32'h81C3E008, 1'b0));
        tick();
        check_exp("same_byte_new", 32'h11C3E008, model_ctrl(32'h11C3E008, 1'b0));

        bus.LE = 0;
        for (int i = 0; i < 3; i++) begin
            bus.pc = 8'($urandom_range(0, 255));
            tick();
            check_exp($sformatf("le_hold_%0d", i), 32'h11C3E008, model_ctrl(32'h11C3E008, 1'b0));
        end

        write_byte(8'd255, 8'hAA);
        write_byte(8'd0,   8'hBB);
        write_byte(8'd1,   8'hCC);
        write_byte(8'd2,   8'hDD);
        bus.pc = 8'd255; bus.LE = 1; tick(); bus.LE = 0;
        check_exp("wrap_fetch", 32'hAABBCCDD, model_ctrl(32'hAABBCCDD, 1'b0));

        for (int i = 0; i < 400; i++) begin
            bus.mem_we    = ($urandom_range(0, 3) == 0);
            bus.mem_waddr = 8'($urandom_range(0, 255));
            bus.mem_wdata = 8'($urandom);
            bus.pc        = 8'($urandom_range(0, 255));
            bus.LE        = ($urandom_range(0, 3) != 0);
            bus.S         = ($urandom_range(0, 3) == 0);
            tick();
            check_model("random");
            if ($urandom_range(0, 49) == 0) begin
                #2 R = 0; m_instr = '0; #1;
                check_model("random_reset");
                R = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_decode_control.md
Name: id_decode_control

Overview:
- Instruction-fetch/decode control block for the SPARC-subset pipeline.
- Holds a byte-addressed instruction memory and an IF/ID instruction register.
- Decodes the registered instruction into ID-stage control signals.
- Passes those signals through a hazard/bubble mux that forces them all to zero on request. The outputs feed the ID/EX pipeline register.

Parameters:
- MEM_DEPTH, 256, instruction memory size in bytes.
- ADDR_W, 8, byte-address width; MEM_DEPTH = 2**ADDR_W.

Ports:
- Clk  in  1  rising-edge clock.
- R  in  1  reset, asynchronous, active-low.
- LE  in  1  IF/ID register load enable.
- S  in  1  bubble select; 1 zeroes all control outputs.
- mem_we  in  1  instruction memory write enable, used for preload.
- mem_waddr  in  ADDR_W  preload byte address.
- mem_wdata  in  8  preload byte.
- pc  in  ADDR_W  fetch byte address.
- instr  out  32  IF/ID register contents.
- jmpl_instr, Read_Write, SE_dm, load_instr, RF_enable, modifyCC, Call_instr, B_instr, a_bit  out  1 each  control signals.
- size_dm  out  2  data-memory access size.
- ALU_op3  out  6  ALU operation code.

Behaviour:
- Memory write: synchronous; when mem_we=1 at the rising edge of Clk, mem[mem_waddr] <= mem_wdata. Memory contents are not affected by reset.
- Memory read: combinational and big-endian. fetch = {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]}. Address addition wraps modulo MEM_DEPTH, so pc=255 reads bytes 255, 0, 1, 2.
- IF/ID register:
  - R=0 clears instr to 0 immediately, independent of Clk.
  - Otherwise, on a rising edge with LE=1, instr <= fetch; with LE=0 it holds its value.
- Decode: combinational from instr. op=instr[31:30], op2=instr[24:22], op3=instr[24:19]. Signals not listed for a case are 0.
  - op=01 (call): Call_instr=1, RF_enable=1, ALU_op3=000000.
  - op=00, op2=010 (Bicc): B_instr=1, a_bit=instr[29].
  - op=00, op2=100 (sethi/nop): RF_enable=1, ALU_op3=001110 (pass-B code).
  - op=00, any other op2: all signals 0. This covers instr=0 after reset.
  - op=10, op3[5]=0: RF_enable=1, ALU_op3=op3, modifyCC=op3[4].
  - op=10, op3 in {100101, 100110, 100111} (shifts): RF_enable=1, ALU_op3=op3.
  - op=10, op3=111000 (jmpl): jmpl_instr=1, RF_enable=1, ALU_op3=000000.
  - op=10, any other op3: all signals 0.
  - op=11 (load/store): ALU_op3=000000.
    - Store when op3[2]=1: Read_Write=1 (write), load_instr=0, RF_enable=0.
    - Otherwise load: load_instr=1, RF_enable=1, Read_Write=0, SE_dm=op3[3].
    - size_dm from op3[1:0]: 01→00 (byte), 10→01 (half), 00→10 (word), 11→11 (double).
- Bubble mux: combinational. S=1 drives every control output, including a_bit and ALU_op3, to 0. S=0 passes the decode values. instr is unaffected by S.
- Latency: a byte preloaded at edge k is visible on fetch immediately after that edge. It reaches instr at the next LE=1 edge. Control outputs follow instr with zero cycles of added latency.
- Reset state: instr=0, so every control output is 0 regardless of S.
- Simultaneous events:
  - Preload write and fetch of the same byte: fetch reflects the old value before the edge and the new value after it.
  - Reset asserted together with LE: reset wins.

Optional Feature:
- Macro ILLEGAL_INSTR_DETECT_EN.
- When defined: adds output illegal_instr (1 bit). It is 1 when instr falls in an "any other" decode case and instr is not all-zero. It is forced to 0 when S=1 or during reset.
- When undefined: the port is absent and the decode is unchanged.

Test Plan:
- Reset and hold:
  - Drive R=0 asynchronously mid-cycle with instr=0x86804002 → instr=0 and all control outputs 0 at once.
  - Release R; next LE=1 edge reloads instr from pc.
- Call and branch:
  - Preload 0x40000010 at addr 0, pc=0, one edge → Call_instr=1, RF_enable=1, ALU_op3=000000.
  - 0x30800004 at pc=4 → B_instr=1, a_bit=1.
- ALU ops:
  - 0x86804002 (addcc) → ALU_op3=010000, modifyCC=1, RF_enable=1.
  - 0x81C3E008 (jmpl) → jmpl_instr=1, RF_enable=1, ALU_op3=000000.
- Loads and stores:
  - 0xC6084002 (ldub) → load_instr=1, RF_enable=1, SE_dm=0, size_dm=00, Read_Write=0.
  - 0xC6284002 (stb) → Read_Write=1, load_instr=0, RF_enable=0, size_dm=00.
- Bubble: with addcc in instr, raise S=1 → all control outputs 0 while instr stays 0x86804002; drop S → values return.
- Wrap and LE:
  - Preload bytes 0xAA, 0xBB, 0xCC, 0xDD at addrs 255, 0, 1, 2; pc=255 → instr=0xAABBCCDD.
  - With LE=0, changing pc leaves instr unchanged across edges.
